// File: rtl/mobo_bus_arbiter_pkg.sv
// Shared constants for the motherboard port arbiter: control/status bit
// positions, arbiter state encoding and a small index helper.
package mobo_bus_arbiter_pkg;

  localparam int WORD_WIDTH = 32;

  localparam int MOBO_CTRL_VALID = 0;
  localparam int MOBO_CTRL_WE    = 1;

  localparam int MOBO_STAT_ACK = 0;
  localparam int MOBO_STAT_ERR = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } arb_state_t;

  // Increment a requester index with wrap at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mobo_bus_arbiter_if.sv
// Motherboard read/write port: command/address/data toward the board,
// status and read data back. master = arbiter side, slave = board side.
interface mobo_bus_arbiter_if
  import mobo_bus_arbiter_pkg::*;
#(
  parameter int word_width = WORD_WIDTH
);
  logic [word_width-1:0] ctrl;
  logic [word_width-1:0] addr;
  logic [word_width-1:0] wdata;
  logic [word_width-1:0] stat;
  logic [word_width-1:0] rdata;

  modport master (output ctrl, output addr, output wdata, input stat, input rdata);
  modport slave  (input ctrl, input addr, input wdata, output stat, output rdata);
endinterface

// File: rtl/mobo_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from
// rr_ptr with wrap.
module mobo_bus_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_req
);
  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    grant_idx = '0;
    any_req   = |req;
    // Scan from farthest to nearest so the nearest hit is the one kept.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        grant_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
    grant = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/mobo_bus_arbiter.sv
// Round-robin arbiter sharing the single motherboard port between CPU-side
// requesters; latches the winning command and runs the ctrl/stat handshake.
//
//   state | meaning
//   IDLE  | no command outstanding, arbitrate on req
//   ISSUE | CMD_VALID driven, waiting for ACK/ERR or timeout
//   DONE  | done/err pulse to the winner, advance rr_ptr
module mobo_bus_arbiter
  import mobo_bus_arbiter_pkg::*;
#(
  parameter int word_width = WORD_WIDTH,
  parameter int NUM_REQ    = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*word_width-1:0] req_addr,
  input  logic [NUM_REQ*word_width-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic [word_width-1:0]         rdata,
  mobo_bus_arbiter_if.master            mobo,
  output logic                          busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  id;
  logic              we;
  logic [CNT_W-1:0]  cnt;

  logic [NUM_REQ-1:0]    win_oh;
  logic [IDX_W-1:0]      win_idx;
  logic                  any_req;
  logic [NUM_REQ-1:0]    id_oh;
  logic [word_width-1:0] cmd_word;
  logic                  stat_ack;
  logic                  stat_err;
  logic                  timeout_hit;
  logic                  unused_stat;

  mobo_bus_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  assign id_oh       = NUM_REQ'(1) << id;
  assign stat_ack    = mobo.stat[MOBO_STAT_ACK];
  assign stat_err    = mobo.stat[MOBO_STAT_ERR];
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign unused_stat = ^mobo.stat[word_width-1:2];

  always_comb begin
    cmd_word                  = '0;
    cmd_word[MOBO_CTRL_VALID] = 1'b1;
    cmd_word[MOBO_CTRL_WE]    = req_we[win_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id         <= '0;
      we         <= 1'b0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= '0;
      rdata      <= '0;
      mobo.ctrl  <= '0;
      mobo.addr  <= '0;
      mobo.wdata <= '0;
      busy       <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            id         <= win_idx;
            we         <= req_we[win_idx];
            mobo.addr  <= req_addr[win_idx*word_width +: word_width];
            mobo.wdata <= req_wdata[win_idx*word_width +: word_width];
            mobo.ctrl  <= cmd_word;
            gnt        <= win_oh;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (stat_err || stat_ack || timeout_hit) begin
            mobo.ctrl <= '0;
            done      <= id_oh;
            // A timeout coinciding with ACK still counts as success.
            err       <= (stat_err || !stat_ack) ? id_oh : '0;
            if (!stat_err && stat_ack && !we) rdata <= mobo.rdata;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done   <= '0;
          err    <= '0;
          rr_ptr <= IDX_W'(wrap_inc(32'(id), NUM_REQ));
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mobo_bus_arbiter.sv
// Directed bench for mobo_bus_arbiter: table of single transactions plus
// hand sequences for round-robin, late ACK and reset mid-transaction.
module tb_mobo_bus_arbiter;
  import mobo_bus_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req, req_we, gnt, done, err;
  logic [N*W-1:0] req_addr, req_wdata;
  logic [W-1:0]   rdata;
  logic           busy;

  mobo_bus_arbiter_if #(.word_width(W)) mobo();

  mobo_bus_arbiter #(.word_width(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mobo      (mobo),
    .busy      (busy)
  );

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] stat;
    logic [31:0] mrdata;
    logic        exp_err;
    int          exp_cv;
  } vec_t;

  vec_t        vecs[7];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [W-1:0] model_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic we, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata);
    req                 = '0;
    req[id]             = 1'b1;
    req_we[id]          = we;
    req_addr[id*W +: W]  = addr;
    req_wdata[id*W +: W] = wdata;
  endtask

  task automatic run_txn(input vec_t v);
    logic [N-1:0] oh;
    logic [W-1:0] exp_ctrl;
    int           cv;
    bit           fin;
    bit           hold_bad;
    oh       = N'(1) << v.id;
    exp_ctrl = {30'b0, v.we, 1'b1};
    @(negedge clk);
    set_req(v.id, v.we, v.addr, v.wdata);
    mobo.stat = '0;
    @(negedge clk);
    chk("gnt", {61'b0, gnt}, {61'b0, oh});
    chk("ctrl_issue", {32'b0, mobo.ctrl}, {32'b0, exp_ctrl});
    chk("mobo_addr", {32'b0, mobo.addr}, {32'b0, v.addr});
    chk("mobo_wdata", {32'b0, mobo.wdata}, {32'b0, v.wdata});
    // Changing the request after grant must not reach the bus.
    req_addr[v.id*W +: W]  = ~v.addr;
    req_wdata[v.id*W +: W] = ~v.wdata;
    cv = 0; fin = 1'b0; hold_bad = 1'b0;
    for (int k = 0; k < 16 && !fin; k++) begin
      if (k > 0) @(negedge clk);
      if (mobo.ctrl[MOBO_CTRL_VALID]) begin
        cv++;
        if (mobo.ctrl !== exp_ctrl || mobo.addr !== v.addr || mobo.wdata !== v.wdata)
          hold_bad = 1'b1;
        if (cv - 1 == v.delay) begin
          mobo.stat  = v.stat;
          mobo.rdata = v.mrdata;
        end else begin
          mobo.stat  = '0;
          mobo.rdata = ~v.mrdata;
        end
      end else begin
        fin = 1'b1;
      end
    end
    mobo.stat = '0;
    req       = '0;
    chk("done_reached", {63'b0, fin}, 64'd1);
    chk("cmd_valid_cycles", 64'(cv), 64'(v.exp_cv));
    chk("cmd_hold_stable", {63'b0, hold_bad}, 64'd0);
    chk("gnt_one_cycle", {61'b0, gnt}, 64'd0);
    chk("done", {61'b0, done}, {61'b0, oh});
    chk("err", {61'b0, err}, v.exp_err ? {61'b0, oh} : 64'd0);
    if (!v.exp_err && !v.we) model_rdata = v.mrdata;
    chk("rdata", {32'b0, rdata}, {32'b0, model_rdata});
    chk("busy_in_done", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("busy_after_done", {63'b0, busy}, 64'd0);
    chk("done_one_cycle", {61'b0, done}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g_seq[8];
    int           g_cyc[8];
    int           d_cyc[8];
    int           ng, nd;
    logic [N-1:0] exp_g[4];
    int           exp_gc[4];
    int           exp_dc[4];
    vec_t         late;

    vecs[0] = '{0, 1'b0, 32'h40,  32'h0,    0,  32'h1,        32'hDEADBEEF, 1'b0, 1};
    vecs[1] = '{1, 1'b1, 32'h80,  32'h1234, 3,  32'h1,        32'h11111111, 1'b0, 4};
    vecs[2] = '{2, 1'b0, 32'hC0,  32'h0,    1,  32'h3,        32'h00000055, 1'b1, 2};
    vecs[3] = '{0, 1'b0, 32'h44,  32'h0,    99, 32'h0,        32'h22222222, 1'b1, 4};
    vecs[4] = '{2, 1'b0, 32'h100, 32'h0,    2,  32'h1,        32'hCAFEF00D, 1'b0, 3};
    vecs[5] = '{1, 1'b1, 32'h84,  32'h5678, 0,  32'h2,        32'h33333333, 1'b1, 1};
    vecs[6] = '{1, 1'b0, 32'h88,  32'h0,    0,  32'hFFFFFFF1, 32'h0BADF00D, 1'b0, 1};

    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mobo.stat = '0; mobo.rdata = '0;
    model_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_gnt", {61'b0, gnt}, 64'd0);
    chk("rst_done_err", {58'b0, done, err}, 64'd0);
    chk("rst_rdata", {32'b0, rdata}, 64'd0);
    chk("rst_ctrl", {32'b0, mobo.ctrl}, 64'd0);
    chk("rst_addr_wdata", {mobo.addr, mobo.wdata}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {63'b0, busy}, 64'd0);

    // Round-robin with all three requesting and immediate ACK.
    exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_gc = '{1, 4, 7, 10};
    exp_dc = '{2, 5, 8, 11};
    for (int i = 0; i < N; i++) begin
      req_addr[i*W +: W]  = 32'h1000 + 32'(i);
      req_wdata[i*W +: W] = '0;
    end
    req_we = '0;
    req    = '1;
    ng = 0; nd = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (gnt != 0 && ng < 8) begin g_seq[ng] = gnt; g_cyc[ng] = c; ng++; end
      if (done != 0 && nd < 8) begin d_cyc[nd] = c; nd++; end
      mobo.stat  = {31'b0, mobo.ctrl[MOBO_CTRL_VALID]};
      mobo.rdata = 32'hA0 + 32'(c);
    end
    req = '0; mobo.stat = '0;
    model_rdata = 32'hA0 + 32'd10;
    chk("rr_grant_count", 64'(ng), 64'd4);
    chk("rr_done_count", 64'(nd), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        chk("rr_grant_order", {61'b0, g_seq[i]}, {61'b0, exp_g[i]});
        chk("rr_grant_cycle", 64'(g_cyc[i]), 64'(exp_gc[i]));
      end
      if (i < nd) chk("rr_done_cycle", 64'(d_cyc[i]), 64'(exp_dc[i]));
    end
    chk("rr_last_rdata", {32'b0, rdata}, {32'b0, model_rdata});
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // ACK while idle with nothing requested is ignored.
    @(negedge clk);
    mobo.stat  = 32'h1;
    mobo.rdata = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("late_ack_gnt", {61'b0, gnt}, 64'd0);
      chk("late_ack_done", {61'b0, done}, 64'd0);
      chk("late_ack_busy_ctrl", {31'b0, busy, mobo.ctrl}, 64'd0);
      chk("late_ack_rdata", {32'b0, rdata}, {32'b0, model_rdata});
    end
    mobo.stat = '0;
    late = '{0, 1'b0, 32'h48, 32'h0, 0, 32'h1, 32'h600D600D, 1'b0, 1};
    run_txn(late);

    // Reset during ISSUE aborts silently and clears rr_ptr.
    @(negedge clk);
    set_req(1, 1'b1, 32'h200, 32'h77);
    @(negedge clk);
    chk("abort_gnt", {61'b0, gnt}, 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    req = '0;
    model_rdata = '0;
    chk("abort_ctrl", {32'b0, mobo.ctrl}, 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done_err", {58'b0, done, err}, 64'd0);
    chk("abort_rdata", {32'b0, rdata}, 64'd0);
    @(negedge clk);
    chk("abort_no_done", {61'b0, done}, 64'd0);
    rst_n  = 1'b1;
    req_we = '0;
    req    = '1;
    @(negedge clk);
    chk("post_rst_gnt", {61'b0, gnt}, 64'd1);
    chk("post_rst_ctrl", {32'b0, mobo.ctrl}, 64'd1);
    mobo.stat  = 32'h1;
    mobo.rdata = 32'h11;
    @(negedge clk);
    mobo.stat = '0;
    req       = '0;
    chk("post_rst_done", {61'b0, done}, 64'd1);
    chk("post_rst_err", {61'b0, err}, 64'd0);
    chk("post_rst_rdata", {32'b0, rdata}, 64'h11);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
